// File: rtl/axi_pkg.sv
// Shared AXI4 encodings plus the bridge FSM state type.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_XFER = 3'd3,
        ST_WR_RESP = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    // AxSIZE encoding for a full-width beat of the given data bus width in bits.
    function automatic logic [2:0] axsize_from_width(input int unsigned width);
        return 3'($clog2(width / 8));
    endfunction

endpackage

// File: rtl/cpu_axi_master_bridge.sv
// Turns level-held CPU read/write requests into single-beat AXI4 transactions,
// one outstanding at a time, with ready/valid/done pulses back to the controller.
module cpu_axi_master_bridge
    import axi_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic                    read_req,
    input  logic [ADDR_WIDTH-1:0]   read_addr,
    output logic                    read_ready,
    output logic                    read_valid,
    output logic [DATA_WIDTH-1:0]   read_data,
    output logic                    read_done,
    output logic                    read_err,
    input  logic                    write_req,
    input  logic [ADDR_WIDTH-1:0]   write_addr,
    input  logic [DATA_WIDTH-1:0]   write_data,
    output logic                    write_ready,
    output logic                    write_data_ready,
    output logic                    write_done,
    output logic                    write_err,
    output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [7:0]              M_AXI_AWLEN,
    output logic [2:0]              M_AXI_AWSIZE,
    output logic [1:0]              M_AXI_AWBURST,
    output logic [2:0]              M_AXI_AWPROT,
    output logic                    M_AXI_AWVALID,
    input  logic                    M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                    M_AXI_WLAST,
    output logic                    M_AXI_WVALID,
    input  logic                    M_AXI_WREADY,
    input  logic [1:0]              M_AXI_BRESP,
    input  logic                    M_AXI_BVALID,
    output logic                    M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [7:0]              M_AXI_ARLEN,
    output logic [2:0]              M_AXI_ARSIZE,
    output logic [1:0]              M_AXI_ARBURST,
    output logic [2:0]              M_AXI_ARPROT,
    output logic                    M_AXI_ARVALID,
    input  logic                    M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]              M_AXI_RRESP,
    input  logic                    M_AXI_RLAST,
    input  logic                    M_AXI_RVALID,
    output logic                    M_AXI_RREADY
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic [2:0]  AXSIZE     = axsize_from_width(DATA_WIDTH);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d, awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d, read_data_q, read_data_d;
    logic                    arvalid_q, arvalid_d, rready_q, rready_d;
    logic                    awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic                    aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic                    read_ready_q, read_ready_d, read_valid_q, read_valid_d;
    logic                    read_done_q, read_done_d, read_err_q, read_err_d;
    logic                    write_ready_q, write_ready_d, write_data_ready_q, write_data_ready_d;
    logic                    write_done_q, write_done_d, write_err_q, write_err_d;
    logic                    aw_hs_c, w_hs_c;

    // Single beats only: RLAST and the low response bits carry nothing we use.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, M_AXI_RLAST, M_AXI_RRESP[0], M_AXI_BRESP[0]};

    assign aw_hs_c = awvalid_q & M_AXI_AWREADY;
    assign w_hs_c  = wvalid_q & M_AXI_WREADY;

    // Next-state and registered-output logic; done pulses fire on entry to DONE.
    always_comb begin
        state_d            = state_q;
        araddr_d           = araddr_q;
        arvalid_d          = arvalid_q;
        rready_d           = rready_q;
        read_data_d        = read_data_q;
        read_err_d         = read_err_q;
        awaddr_d           = awaddr_q;
        awvalid_d          = awvalid_q;
        wdata_d            = wdata_q;
        wvalid_d           = wvalid_q;
        bready_d           = bready_q;
        write_err_d        = write_err_q;
        aw_done_d          = aw_done_q;
        w_done_d           = w_done_q;
        read_ready_d       = 1'b0;
        read_valid_d       = 1'b0;
        read_done_d        = 1'b0;
        write_ready_d      = 1'b0;
        write_data_ready_d = 1'b0;
        write_done_d       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (read_req) begin
                    araddr_d  = read_addr;
                    arvalid_d = 1'b1;
                    state_d   = ST_RD_ADDR;
                end else if (write_req) begin
                    awaddr_d  = write_addr;
                    wdata_d   = write_data;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = ST_WR_XFER;
                end
            end
            ST_RD_ADDR: begin
                if (M_AXI_ARREADY) begin
                    arvalid_d    = 1'b0;
                    read_ready_d = 1'b1;
                    rready_d     = 1'b1;
                    state_d      = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (M_AXI_RVALID) begin
                    read_data_d  = M_AXI_RDATA;
                    read_err_d   = M_AXI_RRESP[1];
                    read_valid_d = 1'b1;
                    read_done_d  = 1'b1;
                    rready_d     = 1'b0;
                    state_d      = ST_DONE;
                end
            end
            ST_WR_XFER: begin
                if (aw_hs_c) begin
                    awvalid_d     = 1'b0;
                    write_ready_d = 1'b1;
                    aw_done_d     = 1'b1;
                end
                if (w_hs_c) begin
                    wvalid_d           = 1'b0;
                    write_data_ready_d = 1'b1;
                    w_done_d           = 1'b1;
                end
                if ((aw_done_q | aw_hs_c) && (w_done_q | w_hs_c)) begin
                    bready_d = 1'b1;
                    state_d  = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                if (M_AXI_BVALID) begin
                    write_err_d  = M_AXI_BRESP[1];
                    write_done_d = 1'b1;
                    bready_d     = 1'b0;
                    state_d      = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q            <= ST_IDLE;
            araddr_q           <= '0;
            arvalid_q          <= 1'b0;
            rready_q           <= 1'b0;
            read_data_q        <= '0;
            read_err_q         <= 1'b0;
            awaddr_q           <= '0;
            awvalid_q          <= 1'b0;
            wdata_q            <= '0;
            wvalid_q           <= 1'b0;
            bready_q           <= 1'b0;
            write_err_q        <= 1'b0;
            aw_done_q          <= 1'b0;
            w_done_q           <= 1'b0;
            read_ready_q       <= 1'b0;
            read_valid_q       <= 1'b0;
            read_done_q        <= 1'b0;
            write_ready_q      <= 1'b0;
            write_data_ready_q <= 1'b0;
            write_done_q       <= 1'b0;
        end else begin
            state_q            <= state_d;
            araddr_q           <= araddr_d;
            arvalid_q          <= arvalid_d;
            rready_q           <= rready_d;
            read_data_q        <= read_data_d;
            read_err_q         <= read_err_d;
            awaddr_q           <= awaddr_d;
            awvalid_q          <= awvalid_d;
            wdata_q            <= wdata_d;
            wvalid_q           <= wvalid_d;
            bready_q           <= bready_d;
            write_err_q        <= write_err_d;
            aw_done_q          <= aw_done_d;
            w_done_q           <= w_done_d;
            read_ready_q       <= read_ready_d;
            read_valid_q       <= read_valid_d;
            read_done_q        <= read_done_d;
            write_ready_q      <= write_ready_d;
            write_data_ready_q <= write_data_ready_d;
            write_done_q       <= write_done_d;
        end
    end

    assign read_ready       = read_ready_q;
    assign read_valid       = read_valid_q;
    assign read_data        = read_data_q;
    assign read_done        = read_done_q;
    assign read_err         = read_err_q;
    assign write_ready      = write_ready_q;
    assign write_data_ready = write_data_ready_q;
    assign write_done       = write_done_q;
    assign write_err        = write_err_q;

    assign M_AXI_AWADDR  = awaddr_q;
    assign M_AXI_AWLEN   = 8'd0;
    assign M_AXI_AWSIZE  = AXSIZE;
    assign M_AXI_AWBURST = BURST_INCR;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = {STRB_WIDTH{1'b1}};
    assign M_AXI_WLAST   = 1'b1;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARLEN   = 8'd0;
    assign M_AXI_ARSIZE  = AXSIZE;
    assign M_AXI_ARBURST = BURST_INCR;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

endmodule

// File: doc/cpu_axi_master_bridge.md
Name: cpu_axi_master_bridge

Overview:
Downstream neighbour of the CPU controller. Converts its level-held read_req/write_req request interface into single-beat AXI4 transactions on one master port. Issues one outstanding transaction at a time and returns ready, valid and done pulses plus read data to the controller. The bridge's AXI master port connects directly to the interconnect.

Parameters:
ADDR_WIDTH, 32, address width of requests and AXI AxADDR
DATA_WIDTH, 32, data width (32 or 64); sets AxSIZE and WSTRB width

Ports:
ACLK  in  1  clock
ARESETN  in  1  asynchronous active-low reset
read_req  in  1  read request, held high until read_done
read_addr  in  ADDR_WIDTH  read byte address, sampled on acceptance
read_ready  out  1  1-cycle pulse on AR handshake
read_valid  out  1  1-cycle pulse on R handshake
read_data  out  DATA_WIDTH  registered RDATA, held until the next R handshake
read_done  out  1  1-cycle pulse; read_data valid
read_err  out  1  equals RRESP[1] of the last read; valid with read_done
write_req  in  1  write request, held high until write_done
write_addr  in  ADDR_WIDTH  write byte address, sampled on acceptance
write_data  in  DATA_WIDTH  write data, sampled on acceptance
write_ready  out  1  1-cycle pulse on AW handshake
write_data_ready  out  1  1-cycle pulse on W handshake
write_done  out  1  1-cycle pulse after B handshake
write_err  out  1  equals BRESP[1]; valid with write_done
M_AXI_AWADDR/AWLEN/AWSIZE/AWBURST/AWPROT/AWVALID  out  ADDR_WIDTH/8/3/2/3/1  AW channel
M_AXI_AWREADY  in  1
M_AXI_WDATA/WSTRB/WLAST/WVALID  out  DATA_WIDTH/DATA_WIDTH/8/1/1  W channel
M_AXI_WREADY  in  1
M_AXI_BRESP/BVALID  in  2/1;  M_AXI_BREADY  out  1
M_AXI_ARADDR/ARLEN/ARSIZE/ARBURST/ARPROT/ARVALID  out  ADDR_WIDTH/8/3/2/3/1  AR channel
M_AXI_ARREADY  in  1
M_AXI_RDATA/RRESP/RLAST/RVALID  in  DATA_WIDTH/2/1/1;  M_AXI_RREADY  out  1

Behaviour:
- Single clock ACLK. Reset asynchronous, active-low on ARESETN; all flops clear immediately.
- Reset values: all outputs 0 (valids, readies, pulses, read_data, error flags, addresses, WDATA).
- Constant outputs: AxLEN=0, AxBURST=INCR (2'b01), AxSIZE=log2(DATA_WIDTH/8), AxPROT=3'b000, WSTRB all ones, WLAST=1.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_XFER, WR_RESP, DONE.
- IDLE:
  - If read_req is high, latch read_addr into ARADDR, set ARVALID and go to RD_ADDR.
  - Otherwise, if write_req is high, latch write_addr and write_data, set AWVALID and WVALID and go to WR_XFER.
  - Read has priority when both requests are high.
- RD_ADDR: hold ARVALID and ARADDR stable until ARREADY. On the handshake, clear ARVALID, pulse read_ready, set RREADY and go to RD_DATA.
- RD_DATA: on RVALID&RREADY:
  - capture RDATA into read_data and RRESP[1] into read_err;
  - pulse read_valid, clear RREADY, go to DONE.
  - RLAST is ignored.
- WR_XFER:
  - AW and W are issued concurrently and tracked by aw_done/w_done flags.
  - On AWREADY, clear AWVALID and pulse write_ready.
  - On WREADY, clear WVALID and pulse write_data_ready.
  - Both handshakes may occur in the same cycle.
  - Once both flags are set, including same-cycle completion, set BREADY and go to WR_RESP.
- WR_RESP: on BVALID, capture BRESP[1] into write_err, clear BREADY, go to DONE.
- DONE: pulse read_done or write_done for exactly one cycle (whichever operation ran), then return to IDLE.
- The IDLE sample on the cycle after DONE sees the controller's next request. This gap is mandatory so a held request is never double-issued.
- Minimum latency with always-ready slave:
  - read: request to read_done = 4 cycles (IDLE, RD_ADDR, RD_DATA, DONE);
  - write: 4 cycles.
- Valids never deassert before their handshake; payload stays stable while valid (AXI rule).
- Requests are ignored outside IDLE.
- SLVERR/DECERR: the transaction still completes normally; only the err flag is set.
- Reset mid-transaction: state returns to IDLE, valids drop, no done pulse. The interconnect is reset by the same ARESETN.

Decomposition:
- Shared package axi_pkg holds:
  - BURST_FIXED/INCR/WRAP;
  - RESP_OKAY/EXOKAY/SLVERR/DECERR;
  - a size-from-width function;
  - the FSM state encoding.
- Single module; no sub-module is needed.

Test Plan:
1. Read from 0x10, slave ARREADY=1, RVALID the next cycle with 0xDEADBEEF -> read_ready, read_valid, read_done pulse one cycle each; read_data=0xDEADBEEF; read_done 4 cycles after read_req.
2. Write 0x55AA to 0x20, AWREADY delayed 3 cycles, WREADY immediate -> write_data_ready before write_ready; BREADY only after both; write_done once after BVALID.
3. AWREADY and WREADY high in the same cycle -> both pulses in one cycle; direct move to WR_RESP.
4. Back-to-back controller sequence: read 0x04, read 0x08, write 0x0C -> three transactions with correct addresses; no duplicate AR issued while a request is held.
5. RRESP=SLVERR (2'b10) -> read_done with read_err=1; data still captured; next read with OKAY clears read_err.
6. ARESETN low while in RD_DATA -> RREADY and ARVALID drop immediately; no read_done; after release, a new read_req completes normally.
